window_controller: RTL and testbench

- Sequences the SPARC register-window file: owns the current window pointer (CWP) and window invalid mask (WIM).
- Executes SAVE/RESTORE, trap-entry and WRPSR/WRWIM updates; detects window overflow/underflow and raises a trap handshake.
- Drives one-hot window enables, overlap (next-window) enables and the global file enable (RFE) consumed by the register window blocks.

---
 rtl/win_pkg.sv | 17 +
 rtl/win_decoder.sv | 12 +
 rtl/window_controller.sv | 119 +++++++++++
 tb/tb_window_controller.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/win_pkg.sv
// Shared encodings for the register-window controller: FSM states,
// window trap type codes and the default window count.
package win_pkg;

  localparam int NWIN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    TRAP   = 2'd2
  } state_t;

  localparam logic [1:0] TT_NONE = 2'b00;
  localparam logic [1:0] TT_OVF  = 2'b01;
  localparam logic [1:0] TT_UNF  = 2'b10;

endpackage

// File: rtl/win_decoder.sv
// Binary window index to one-hot window enable.
module win_decoder #(
  parameter int NWIN = 4,
  parameter int CWPW = $clog2(NWIN)
) (
  input  logic [CWPW-1:0] idx,
  output logic [NWIN-1:0] onehot
);

  assign onehot = NWIN'(1) << idx;

endmodule

// File: rtl/window_controller.sv
// SPARC register-window sequencer: owns CWP/WIM, retires SAVE/RESTORE/trap-entry
// and PSR/WIM writes, and raises overflow/underflow traps to the trap unit.
module window_controller
  import win_pkg::*;
#(
  parameter int NWIN = NWIN_DEF,
  parameter int CWPW = $clog2(NWIN)
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            Save,
  input  logic            Restore,
  input  logic            TrapEntry,
  input  logic            WrCwp,
  input  logic            WrWim,
  input  logic [31:0]     WrData,
  input  logic            TrapAck,
  output logic            Ready,
  output logic            Done,
  output logic            TrapReq,
  output logic [1:0]      TrapType,
  output logic [CWPW-1:0] Cwp,
  output logic [NWIN-1:0] Wim,
  output logic [NWIN-1:0] WinEn,
  output logic [NWIN-1:0] NextWinEn,
  output logic            RFE
);

  state_t          state;
  logic [CWPW-1:0] cwp_dec;
  logic [CWPW-1:0] cwp_inc;
  logic            unused_bits;

  // Modulo-NWIN neighbours fall out of natural CWPW-bit wrap.
  assign cwp_dec     = Cwp - CWPW'(1);
  assign cwp_inc     = Cwp + CWPW'(1);
  assign unused_bits = ^WrData;

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state    <= IDLE;
      Cwp      <= '0;
      Wim      <= '0;
      TrapReq  <= 1'b0;
      TrapType <= TT_NONE;
      Done     <= 1'b0;
      Ready    <= 1'b1;
      RFE      <= 1'b1;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (TrapEntry || WrCwp || WrWim || Save || Restore) begin
            state <= COMMIT;
            Done  <= 1'b1;
            Ready <= 1'b0;
          end
          // Fixed priority; lower-priority requests this cycle are dropped.
          if (TrapEntry) begin
            Cwp <= cwp_dec;
          end else if (WrCwp) begin
            Cwp <= WrData[CWPW-1:0];
          end else if (WrWim) begin
            Wim <= WrData[NWIN-1:0];
          end else if (Save) begin
            if (Wim[cwp_dec]) begin
              state    <= TRAP;
              Done     <= 1'b0;
              TrapReq  <= 1'b1;
              TrapType <= TT_OVF;
              RFE      <= 1'b0;
            end else begin
              Cwp <= cwp_dec;
            end
          end else if (Restore) begin
            if (Wim[cwp_inc]) begin
              state    <= TRAP;
              Done     <= 1'b0;
              TrapReq  <= 1'b1;
              TrapType <= TT_UNF;
              RFE      <= 1'b0;
            end else begin
              Cwp <= cwp_inc;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          Ready <= 1'b1;
        end
        TRAP: begin
          if (TrapAck) begin
            state    <= COMMIT;
            Done     <= 1'b1;
            TrapReq  <= 1'b0;
            TrapType <= TT_NONE;
            RFE      <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Ready <= 1'b1;
          RFE   <= 1'b1;
        end
      endcase
    end
  end

  win_decoder #(.NWIN(NWIN), .CWPW(CWPW)) u_win_dec (
    .idx    (Cwp),
    .onehot (WinEn)
  );

  win_decoder #(.NWIN(NWIN), .CWPW(CWPW)) u_next_dec (
    .idx    (cwp_dec),
    .onehot (NextWinEn)
  );

endmodule

// File: tb/tb_window_controller.sv
// Bench for window_controller (NWIN=4): table of single-request vectors through
// a scoreboard queue, plus hand sequences for traps, reset-in-trap and held requests.
module tb_window_controller;

  localparam int NWIN = 4;
  localparam int CWPW = 2;

  logic            Clk = 1'b0;
  logic            Clr, Save, Restore, TrapEntry, WrCwp, WrWim, TrapAck;
  logic [31:0]     WrData;
  logic            Ready, Done, TrapReq, RFE;
  logic [1:0]      TrapType;
  logic [CWPW-1:0] Cwp;
  logic [NWIN-1:0] Wim, WinEn, NextWinEn;

  window_controller #(.NWIN(NWIN), .CWPW(CWPW)) dut (
    .Clk(Clk), .Clr(Clr), .Save(Save), .Restore(Restore), .TrapEntry(TrapEntry),
    .WrCwp(WrCwp), .WrWim(WrWim), .WrData(WrData), .TrapAck(TrapAck),
    .Ready(Ready), .Done(Done), .TrapReq(TrapReq), .TrapType(TrapType),
    .Cwp(Cwp), .Wim(Wim), .WinEn(WinEn), .NextWinEn(NextWinEn), .RFE(RFE)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        sv, rs, te, wc, ww;
    logic [31:0] data;
    logic [1:0]  cwp;
    logic [3:0]  wim, win, nxt;
  } vec_t;

  vec_t vecs[12];
  vec_t exp_q[$];
  vec_t e;
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Called at a negedge; holds the request across one rising edge.
  task automatic pulse(input logic sv, input logic rs, input logic te, input logic wc,
                       input logic ww, input logic [31:0] data);
    Save = sv; Restore = rs; TrapEntry = te; WrCwp = wc; WrWim = ww; WrData = data;
    @(posedge Clk); #1;
    Save = 0; Restore = 0; TrapEntry = 0; WrCwp = 0; WrWim = 0; WrData = '0;
  endtask

  task automatic ack_trap();
    @(negedge Clk); TrapAck = 1'b1;
    @(posedge Clk); #1 TrapAck = 1'b0;
    @(negedge Clk);
    check("ack_done", Done, 1); check("ack_trapreq", TrapReq, 0);
    check("ack_traptype", TrapType, 0); check("ack_ready", Ready, 0); check("ack_rfe", RFE, 1);
    @(negedge Clk);
    check("ack_ready_after", Ready, 1); check("ack_done_after", Done, 0);
  endtask

  initial begin
    //            sv    rs    te    wc    ww    data           cwp    wim      win      nxt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd3, 4'b0000, 4'b1000, 4'b0100};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd2, 4'b0000, 4'b0100, 4'b0010};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd1, 4'b0000, 4'b0010, 4'b0001};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 4'b0000, 4'b0001, 4'b1000};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         2'd1, 4'b0000, 4'b0010, 4'b0001};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF2, 2'd2, 4'b0000, 4'b0100, 4'b0010};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF1, 2'd2, 4'b0001, 4'b0100, 4'b0010};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1,         2'd1, 4'b0001, 4'b0010, 4'b0001};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2,         2'd0, 4'b0001, 4'b0001, 4'b1000};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         2'd0, 4'b0000, 4'b0001, 4'b1000};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         2'd1, 4'b0000, 4'b0010, 4'b0001};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3,         2'd3, 4'b0000, 4'b1000, 4'b0100};

    Clr = 0; Save = 0; Restore = 0; TrapEntry = 0; WrCwp = 0; WrWim = 0; TrapAck = 0;
    WrData = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Clr = 1;
    check("rst_cwp", Cwp, 0); check("rst_wim", Wim, 0); check("rst_trapreq", TrapReq, 0);
    check("rst_traptype", TrapType, 0); check("rst_done", Done, 0); check("rst_ready", Ready, 1);
    check("rst_rfe", RFE, 1); check("rst_winen", WinEn, 4'b0001);
    check("rst_nextwinen", NextWinEn, 4'b1000);

    for (int i = 0; i < 12; i++) begin
      pulse(vecs[i].sv, vecs[i].rs, vecs[i].te, vecs[i].wc, vecs[i].ww, vecs[i].data);
      exp_q.push_back(vecs[i]);
      @(negedge Clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d_cwp", i), Cwp, e.cwp);
      check($sformatf("v%0d_wim", i), Wim, e.wim);
      check($sformatf("v%0d_winen", i), WinEn, e.win);
      check($sformatf("v%0d_nextwinen", i), NextWinEn, e.nxt);
      check($sformatf("v%0d_done", i), Done, 1);
      check($sformatf("v%0d_busy", i), Ready, 0);
      check($sformatf("v%0d_trapreq", i), TrapReq, 0);
      @(negedge Clk);
      check($sformatf("v%0d_ready", i), Ready, 1);
      check($sformatf("v%0d_done_end", i), Done, 0);
    end

    // Overflow: Cwp=3, Wim=0100, Save targets window 2.
    pulse(0, 0, 0, 0, 1, 32'h4);
    @(negedge Clk); check("ovf_wim", Wim, 4'b0100);
    @(negedge Clk);
    pulse(1, 0, 0, 0, 0, 32'h0);
    @(negedge Clk);
    check("ovf_trapreq", TrapReq, 1); check("ovf_type", TrapType, 2'b01);
    check("ovf_rfe", RFE, 0); check("ovf_ready", Ready, 0);
    check("ovf_cwp", Cwp, 3); check("ovf_done", Done, 0);
    repeat (4) @(negedge Clk);
    check("ovf_held", TrapReq, 1); check("ovf_held_cwp", Cwp, 3);
    ack_trap();
    check("ovf_cwp_after", Cwp, 3);

    // Underflow: Wim=0001, Cwp=3, Restore wraps to window 0.
    pulse(0, 0, 0, 0, 1, 32'h1);
    repeat (2) @(negedge Clk);
    pulse(0, 1, 0, 0, 0, 32'h0);
    @(negedge Clk);
    check("unf_trapreq", TrapReq, 1); check("unf_type", TrapType, 2'b10);
    check("unf_cwp", Cwp, 3); check("unf_rfe", RFE, 0);
    ack_trap();
    pulse(0, 0, 0, 0, 1, 32'h0);
    repeat (2) @(negedge Clk);
    pulse(0, 1, 0, 0, 0, 32'h0);
    @(negedge Clk);
    check("wrap_cwp", Cwp, 0); check("wrap_done", Done, 1); check("wrap_trapreq", TrapReq, 0);
    check("wrap_winen", WinEn, 4'b0001);
    @(negedge Clk);

    // Reset while a trap is pending.
    pulse(0, 0, 0, 0, 1, 32'h8);
    repeat (2) @(negedge Clk);
    pulse(1, 0, 0, 0, 0, 32'h0);
    @(negedge Clk);
    check("clr_pre_trapreq", TrapReq, 1);
    Clr = 0;
    @(posedge Clk); #1 Clr = 1;
    @(negedge Clk);
    check("clr_cwp", Cwp, 0); check("clr_wim", Wim, 0); check("clr_trapreq", TrapReq, 0);
    check("clr_ready", Ready, 1); check("clr_traptype", TrapType, 0); check("clr_rfe", RFE, 1);

    // Save held high: ignored during COMMIT, accepted again once Ready returns.
    Save = 1;
    @(negedge Clk); check("hold1_cwp", Cwp, 3); check("hold1_done", Done, 1);
    @(negedge Clk); check("hold2_cwp", Cwp, 3); check("hold2_done", Done, 0);
    check("hold2_ready", Ready, 1);
    @(negedge Clk); check("hold3_cwp", Cwp, 2); check("hold3_done", Done, 1);
    Save = 0;
    @(negedge Clk);

    // Stray TrapAck while idle has no effect.
    TrapAck = 1;
    @(negedge Clk);
    check("stray_ack_done", Done, 0); check("stray_ack_ready", Ready, 1);
    check("stray_ack_cwp", Cwp, 2);
    TrapAck = 0;
    @(negedge Clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
